fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the decode stage.
- Owns the PC and issues read requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small queue and presents {pc, inst} to decode with a stall-based handshake.
- Redirects on jump_flag from the execute stage, flushing queued and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_queue.sv | 58 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, reset PC,
// the decode bubble encoding and the {pc, inst} queue entry layout.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INST_W           = 32;
   localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} entries between memory responses and decode.
// Flush empties it in one cycle and overrides any enqueue/dequeue in that cycle.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enq,
   input  logic                    deq,
   input  logic                    flush,
   input  fetch_entry_t            wr_data,
   output fetch_entry_t            rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   fetch_entry_t  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (enq) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (deq) rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage is cleared on reset so the presented pc/inst read as zero afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      end else if (enq && !flush) begin
         mem_reg[wr_ptr_reg] <= wr_data;
      end
   end

   assign rd_data = mem_reg[rd_ptr_reg];
   assign full    = (count_reg == DEPTH_W);
   assign empty   = (count_reg == '0);
   assign count   = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues credit-limited in-order memory requests,
// queues responses for decode and squashes in-flight work on a redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        jump_flag,
   input  logic [31:0] jump_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

   logic [31:0]   fetch_pc_reg;
   logic [31:0]   resp_pc_reg;
   logic [CW-1:0] outstanding_reg;
   logic [CW-1:0] drop_reg;

   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  head;
   fetch_entry_t  enq_entry;
   logic          deq;
   logic          enq;
   logic          req_fire;
   logic          resp_ok;
   logic [CW:0]   credit;

   // Credits cover both in-flight requests and queued entries, so every
   // response always has a queue slot waiting for it.
   always_comb begin
      if_valid       = !reset && !q_empty && !jump_flag;
      deq            = if_valid && !stall;
      credit         = {1'b0, outstanding_reg} + {1'b0, q_count};
      imem_req_valid = !reset && !jump_flag && ((credit < QDEPTH_W) || deq);
      req_fire       = imem_req_valid && imem_req_ready;
      resp_ok        = imem_resp_valid && (outstanding_reg != '0);
      enq            = resp_ok && (drop_reg == '0) && !jump_flag;
   end

   assign enq_entry     = '{pc: resp_pc_reg, inst: imem_resp_data};
   assign imem_req_addr = fetch_pc_reg;
   assign if_pc         = head.pc;
   assign if_inst       = head.inst;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         outstanding_reg <= '0;
         drop_reg        <= '0;
      end else if (jump_flag) begin
         // Everything still in flight belongs to the old path and must be discarded.
         fetch_pc_reg    <= word_align(jump_target);
         resp_pc_reg     <= word_align(jump_target);
         outstanding_reg <= outstanding_reg - CW'(resp_ok);
         drop_reg        <= outstanding_reg - CW'(resp_ok);
      end else begin
         if (req_fire) fetch_pc_reg <= fetch_pc_reg + 32'd4;
         outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(resp_ok);
         if (resp_ok) begin
            if (drop_reg != '0) drop_reg <= drop_reg - CW'(1);
            else                resp_pc_reg <= resp_pc_reg + 32'd4;
         end
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .enq     (enq),
      .deq     (deq),
      .flush   (jump_flag),
      .wr_data (enq_entry),
      .rd_data (head),
      .full    (q_full),
      .empty   (q_empty),
      .count   (q_count)
   );

   resp_protocol: assert property (@(posedge clk) disable iff (reset)
      imem_resp_valid |-> (outstanding_reg != '0));

   no_overflow: assert property (@(posedge clk) disable iff (reset)
      enq |-> (!q_full || deq));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with settable latency,
// expected pc/addr streams pushed by stimulus and popped by a monitor.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        jump_flag;
   logic [31:0] jump_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_pc[$];
   logic [31:0] exp_addr[$];

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t pend_q[$];
   int    cyc     = 0;
   int    mem_lat = 1;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .jump_flag       (jump_flag),
      .jump_target     (jump_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_inst         (if_inst)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] base, input int n);
      exp_pc.delete();
      exp_addr.delete();
      for (int i = 0; i < n; i++) begin
         exp_pc.push_back(base + 32'(4 * i));
         exp_addr.push_back(base + 32'(4 * i));
      end
   endtask

   // One clock cycle: drive at the falling edge, return 2 time units later
   // with outputs settled for sampling.
   task automatic step(input logic st, input logic jf, input logic [31:0] jt,
                       input logic rdy, input logic rst);
      @(negedge clk);
      stall          = st;
      jump_flag      = jf;
      jump_target    = jt;
      imem_req_ready = rdy;
      reset          = rst;
      if (rst)     push_seq(32'h0000_0000, 40);
      else if (jf) push_seq(jt & ~32'h3, 40);
      #2;
   endtask

   task automatic wait_two_in_flight(input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         if (pend_q.size() + int'(imem_req_valid && imem_req_ready) == 2) begin
            found = 1'b1;
            break;
         end
      end
      chk1(name, found, 1'b1);
   endtask

   // Instruction memory: in-order, fixed latency per request, drops all on reset.
   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (reset) begin
            pend_q.delete();
            imem_resp_valid = 1'b0;
         end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(pend_q[0].addr);
            void'(pend_q.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
         end
         #2;
         if (imem_req_valid && imem_req_ready)
            pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      end
   end

   // Monitor: every accepted request and every consumed instruction is
   // compared with the head of the expected stream.
   initial begin
      logic [31:0] p;
      forever begin
         @(negedge clk);
         #2;
         if (if_valid && !stall) begin
            if (exp_pc.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_extra_inst: got pc %h, expected none", if_pc);
            end else begin
               p = exp_pc.pop_front();
               chk("sb_pc", if_pc, p);
               chk("sb_inst", if_inst, inst_of(p));
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            if (exp_addr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_extra_req: got addr %h, expected none", imem_req_addr);
            end else begin
               p = exp_addr.pop_front();
               chk("sb_req_addr", imem_req_addr, p);
            end
         end
      end
   end

   initial begin
      logic        found;
      logic [31:0] h;
      reset = 1'b1; stall = 1'b0; jump_flag = 1'b0; jump_target = 32'h0; imem_req_ready = 1'b1;

      // Reset, then streaming with a 1-cycle memory
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_if_valid", if_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk1("c0_req_valid", imem_req_valid, 1'b1);
      chk("c0_req_addr", imem_req_addr, 32'h0);
      chk1("c0_if_valid", if_valid, 1'b0);
      chk("c0_if_pc", if_pc, 32'h0);
      chk("c0_if_inst", if_inst, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk1("c1_if_valid", if_valid, 1'b0);
      chk("c1_req_addr", imem_req_addr, 32'h4);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk1("c2_if_valid", if_valid, 1'b1);
      chk("c2_if_pc", if_pc, 32'h0);
      chk1("c2_req_valid", imem_req_valid, 1'b1);
      chk("c2_req_addr", imem_req_addr, 32'h8);
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Stall for 5 cycles: requests stop, presented entry held
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
         h = exp_pc[0];
         chk1("stall_req_valid", imem_req_valid, 1'b0);
         chk1("stall_if_valid", if_valid, 1'b1);
         chk("stall_if_pc", if_pc, h);
         chk("stall_if_inst", if_inst, inst_of(h));
      end
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Redirect with two requests in flight (3-cycle memory)
      mem_lat = 3;
      wait_two_in_flight("j1_two_in_flight");
      step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
      chk1("j1_if_valid", if_valid, 1'b0);
      chk1("j1_req_valid", imem_req_valid, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         if (if_valid) begin
            chk("j1_first_pc", if_pc, 32'h0000_0100);
            found = 1'b1;
            break;
         end
      end
      chk1("j1_target_seen", found, 1'b1);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Redirect together with stall and a same-cycle response
      mem_lat = 1;
      repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
      chk1("j2_if_valid", if_valid, 1'b0);
      chk1("j2_req_valid", imem_req_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk1("j2_next_req_valid", imem_req_valid, 1'b1);
      chk("j2_next_req_addr", imem_req_addr, 32'h0000_0200);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Back-pressure near the top of the address space, then wrap
      step(1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
         chk1("bp_req_valid", imem_req_valid, 1'b1);
         chk("bp_req_addr", imem_req_addr, 32'hFFFF_FFF8);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_addr2", imem_req_addr, 32'h0000_0000);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Reset mid-stream with two requests outstanding
      mem_lat = 3;
      wait_two_in_flight("mr_two_in_flight");
      mem_lat = 1;
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk1("mr_req_valid", imem_req_valid, 1'b0);
      chk1("mr_if_valid", if_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk1("mr_c0_req_valid", imem_req_valid, 1'b1);
      chk("mr_c0_req_addr", imem_req_addr, 32'h0);
      chk1("mr_c0_if_valid", if_valid, 1'b0);
      chk("mr_c0_if_pc", if_pc, 32'h0);
      chk("mr_c0_if_inst", if_inst, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk1("mr_c1_req_valid", imem_req_valid, 1'b1);
      chk("mr_c1_req_addr", imem_req_addr, 32'h4);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
